// File: rtl/scalar_issue_sched.sv
// Scalar scoreboard: FUST rows for ALU/LD_ST/BRANCH, 32-entry RST, single-issue select.
// Define SCALAR_ISSUE_RR_EN for round-robin issue arbitration (fixed ALU>LD_ST>BRANCH otherwise).
module scalar_issue_sched (
  input  logic        CLK,
  input  logic        RST,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [1:0]  disp_fu,
  input  logic [4:0]  disp_rd,
  input  logic [4:0]  disp_rs1,
  input  logic [4:0]  disp_rs2,
  input  logic        disp_rw_en,
  input  logic [31:0] disp_imm,
  input  logic [2:0]  fu_ready,
  input  logic        wb_valid,
  input  logic [1:0]  wb_fu,
  output logic        issue_valid,
  output logic [2:0]  issue_fu_en,
  output logic [4:0]  issue_rd,
  output logic [4:0]  issue_rs1,
  output logic [4:0]  issue_rs2,
  output logic [31:0] issue_imm,
  output logic [2:0]  busy_fu
);

  localparam int unsigned NUM_FU  = 3;
  localparam int unsigned NUM_REG = 32;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_LD_ST  = 2'd1,
    FU_BRANCH = 2'd2,
    FU_NONE   = 2'd3
  } fu_scalar_t;

  typedef logic [NUM_FU-1:0] fu_bits_t;

  typedef enum logic [1:0] {
    FUST_EMPTY = 2'd0,
    FUST_WAIT  = 2'd1,
    FUST_RDY   = 2'd2,
    FUST_EX    = 2'd3
  } fust_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
  } fust_row_t;

  fust_state_e      st_q      [NUM_FU];
  fust_row_t        row_q     [NUM_FU];
  logic [TAG_W-1:0] rst_tag_q [NUM_REG];
  logic [NUM_REG-1:0] rst_busy_q;
`ifdef SCALAR_ISSUE_RR_EN
  logic [1:0]       rr_ptr;
`endif

  logic             wb_act;
  logic [TAG_W-1:0] wb_tag;
  logic [TAG_W-1:0] disp_tag;
  logic [TAG_W-1:0] src1_tag;
  logic [TAG_W-1:0] src2_tag;
  logic             rd_busy;
  logic             row_free;
  logic             disp_fire;
  logic [TAG_W-1:0] nt1 [NUM_FU];
  logic [TAG_W-1:0] nt2 [NUM_FU];
  fu_bits_t         cand;
  logic             win_valid;
  logic [1:0]       win_idx;

  // Writeback qualification, forwarded RST lookups and dispatch handshake.
  always_comb begin
    wb_tag   = TAG_W'(wb_fu) + TAG_W'(1);
    disp_tag = TAG_W'(disp_fu) + TAG_W'(1);
    wb_act   = 1'b0;
    row_free = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (wb_valid && (wb_fu == 2'(i)) && (st_q[i] == FUST_EX)) wb_act = 1'b1;
      if ((disp_fu == 2'(i)) && (st_q[i] == FUST_EMPTY)) row_free = 1'b1;
    end
    src1_tag = '0;
    if ((disp_rs1 != '0) && !(wb_act && (rst_tag_q[disp_rs1] == wb_tag)))
      src1_tag = rst_tag_q[disp_rs1];
    src2_tag = '0;
    if ((disp_rs2 != '0) && !(wb_act && (rst_tag_q[disp_rs2] == wb_tag)))
      src2_tag = rst_tag_q[disp_rs2];
    rd_busy = (disp_rd != '0) && rst_busy_q[disp_rd] &&
              !(wb_act && (rst_tag_q[disp_rd] == wb_tag));
    disp_ready = row_free && !(disp_rw_en && rd_busy);
    disp_fire  = disp_valid && disp_ready;
    for (int i = 0; i < NUM_FU; i++) begin
      nt1[i] = (wb_act && (row_q[i].t1 == wb_tag)) ? '0 : row_q[i].t1;
      nt2[i] = (wb_act && (row_q[i].t2 == wb_tag)) ? '0 : row_q[i].t2;
    end
  end

  // Issue arbitration over RDY rows whose FU can accept.
  always_comb begin
`ifdef SCALAR_ISSUE_RR_EN
    int idx;
`endif
    for (int i = 0; i < NUM_FU; i++) cand[i] = (st_q[i] == FUST_RDY) && fu_ready[i];
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef SCALAR_ISSUE_RR_EN
    idx = 0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % int'(NUM_FU);
      if (cand[2'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = 2'(idx);
      end
    end
`else
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_valid = 1'b1;
        win_idx   = 2'(i);
      end
    end
`endif
    issue_valid = win_valid;
    issue_fu_en = '0;
    issue_rd    = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_imm   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (win_valid && (win_idx == 2'(i))) begin
        issue_fu_en[i] = 1'b1;
        issue_rd       = row_q[i].rd;
        issue_rs1      = row_q[i].rs1;
        issue_rs2      = row_q[i].rs2;
        issue_imm      = row_q[i].imm;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) busy_fu[i] = (st_q[i] != FUST_EMPTY);
  end

  // Row state machines and RST; release, dispatch and issue never target the same row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        st_q[i]  <= FUST_EMPTY;
        row_q[i] <= '0;
      end
      for (int r = 0; r < NUM_REG; r++) rst_tag_q[r] <= '0;
      rst_busy_q <= '0;
`ifdef SCALAR_ISSUE_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        row_q[i].t1 <= nt1[i];
        row_q[i].t2 <= nt2[i];
        if (wb_act && (wb_fu == 2'(i))) begin
          st_q[i] <= FUST_EMPTY;
        end else if (disp_fire && (disp_fu == 2'(i))) begin
          row_q[i] <= '{rd: disp_rd, rs1: disp_rs1, rs2: disp_rs2, imm: disp_imm,
                        t1: src1_tag, t2: src2_tag};
          st_q[i]  <= ((src1_tag == '0) && (src2_tag == '0)) ? FUST_RDY : FUST_WAIT;
        end else if (win_valid && (win_idx == 2'(i))) begin
          st_q[i] <= FUST_EX;
        end else if ((st_q[i] == FUST_WAIT) && (nt1[i] == '0) && (nt2[i] == '0)) begin
          st_q[i] <= FUST_RDY;
        end
      end
      // x0 is never tracked; a same-cycle dispatch to rd overrides the writeback clear.
      for (int r = 1; r < NUM_REG; r++) begin
        if (disp_fire && disp_rw_en && (disp_rd == REG_W'(r))) begin
          rst_busy_q[r] <= 1'b1;
          rst_tag_q[r]  <= disp_tag;
        end else if (wb_act && (rst_tag_q[r] == wb_tag)) begin
          rst_busy_q[r] <= 1'b0;
          rst_tag_q[r]  <= '0;
        end
      end
`ifdef SCALAR_ISSUE_RR_EN
      if (win_valid) rr_ptr <= (win_idx == 2'(NUM_FU - 1)) ? 2'd0 : win_idx + 2'd1;
`endif
    end
  end

endmodule

// File: doc/scalar_issue_sched.md
Name: scalar_issue_sched

Overview:
- Scoreboard controller for the three scalar functional units: ALU, LD_ST and BRANCH.
- Holds the scalar FUST (one row per FU) and the scalar RST (32 entries of tag plus busy).
- Accepts one dispatched instruction per cycle, tracks RAW/WAW hazards through producer tags, and issues at most one ready row per cycle to the FUs.
- Completion writebacks wake dependent rows and clear RST entries.

Parameters:
- NUM_FU, 3, number of scalar FU rows; index 0=ALU, 1=LD_ST, 2=BRANCH, matching fu_scalar_t encoding.
- NUM_REG, 32, scalar registers tracked in the RST.
- TAG_W, 2, tag width. Tag = FU index + 1; tag 0 = operand available.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  dispatch accepted this cycle
- disp_fu  in  2  target FU (fu_scalar_t)
- disp_rd  in  5  destination register
- disp_rs1  in  5  source register 1
- disp_rs2  in  5  source register 2
- disp_rw_en  in  1  instruction writes disp_rd
- disp_imm  in  32  immediate
- fu_ready  in  3  per-FU can-accept, one bit per FU index
- wb_valid  in  1  FU completion
- wb_fu  in  2  completing FU index
- issue_valid  out  1  issue this cycle
- issue_fu_en  out  3  one-hot FU select (fu_bits_t)
- issue_rd  out  5  issued row rd
- issue_rs1  out  5  issued row rs1
- issue_rs2  out  5  issued row rs2
- issue_imm  out  32  issued row imm
- busy_fu  out  3  per-FU row not EMPTY

Behaviour:
- Reset: all rows FUST_EMPTY, all RST entries tag=0 and busy=0. All outputs 0, except disp_ready, which follows its combinational rule.
- Row states use fust_state_e: EMPTY, WAIT, RDY, EX.
- disp_ready = row[disp_fu] EMPTY AND NOT (disp_rw_en AND disp_rd!=0 AND RST[disp_rd].busy after same-cycle wb clear). This is a WAW stall.
- Dispatch (disp_valid and disp_ready) at edge:
  - Row captures rd, rs1, rs2 and imm.
  - t1 = RST[rs1].tag and t2 = RST[rs2].tag, both read after the same-cycle writeback clear (mandatory forwarding). Register x0 always yields tag 0.
  - If disp_rw_en and rd!=0: RST[rd] busy=1, tag=disp_fu+1.
  - Next state is RDY if t1==0 and t2==0, else WAIT.
- disp_fu=3 is invalid: disp_ready=0.
- Wakeup: on wb_valid, every row with t1 or t2 equal to wb_fu+1 clears that field. A WAIT row whose tags both become 0 moves to RDY at the same edge.
- Writeback clear: every RST entry with tag==wb_fu+1 clears to busy=0, tag=0, unless a same-cycle dispatch sets that rd, in which case the dispatch wins.
- Row release: row[wb_fu] in EX goes to EMPTY. A wb to a non-EX row is ignored; neither the row nor the RST is changed.
- Issue selection:
  - Candidates are rows in RDY with fu_ready[i]=1.
  - Selection is combinational from registered state; one winner per the arbitration policy.
  - issue_valid=1, issue_fu_en=one-hot winner, and operand fields come from the winner row.
  - Winner goes RDY->EX at the edge.
  - No candidate: issue_valid=0 and all issue outputs 0.
- Latency:
  - Dispatch at cycle N gives earliest issue at N+1.
  - wb at N wakes a WAIT row, which can issue at N+1.
  - wb at N frees a row, which can accept a dispatch at N+1.
  - disp_ready does not depend on the same-cycle row release.
- Simultaneous wb and dispatch to the same FU: dispatch is refused that cycle because the row is not yet EMPTY.
- Reset asserted mid-operation returns everything to reset state at the next edge. In-flight wb is discarded.
- busy_fu[i] = row i not EMPTY.

Optional Feature:
- Macro: SCALAR_ISSUE_RR_EN.
- Defined: round-robin arbitration. A pointer starts at 0 on reset and advances to the winner index +1 (mod 3) after each issue. Priority starts at the pointer.
- Undefined: fixed priority ALU > LD_ST > BRANCH, with no pointer state.

Test Plan:
- Reset, then dispatch ALU rd=5 rs1=1 rs2=2 -> disp_ready=1; next cycle issue_valid=1, issue_fu_en=3'b001, RST[5].tag=1 busy=1.
- ALU writes x5 and is in EX; dispatch LD_ST rs1=5 -> row t1=1, state WAIT, no issue. wb_valid, wb_fu=0 -> next cycle issue_fu_en=3'b010; RST[5] clear; ALU row EMPTY.
- x7 busy with tag 2; dispatch rd=7 -> disp_ready=0. Assert wb_fu=1 in the same cycle -> disp_ready=1 and RST[7].tag becomes the new FU's tag.
- All three rows RDY, fu_ready=3'b111, for three cycles -> fixed mode: ALU, LD_ST, BRANCH; with SCALAR_ISSUE_RR_EN the order rotates from pointer 0: 001, 010, 100.
- Row RDY with fu_ready=0 -> issue_valid=0 and the row holds RDY. Raising fu_ready issues it next.
- Dispatch rd=0 rs1=0 -> RST unchanged, row RDY. Assert RST mid-WAIT -> all rows EMPTY, busy_fu=0, RST table clear.
